// File: rtl/main_mem_pkg.sv
// main_mem_pkg: shared FSM state type, latency counter width and address-slicing helpers
package main_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} main_mem_state_e;
  localparam int LAT_CNT_W = 4;
  function automatic int off_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction
  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/main_mem_mc_if.sv
// main_mem_mc_if: per-channel line request bus plus shared read data/ack/busy returned by the memory
interface main_mem_mc_if #(
  parameter int NUM_CH = 2,
  parameter int LINE_W = 128,
  parameter int ADDR_W = 32
);
  logic [NUM_CH-1:0]        req_i;
  logic [NUM_CH-1:0]        w_en_i;
  logic [NUM_CH*ADDR_W-1:0] addr_i;
  logic [NUM_CH*LINE_W-1:0] w_data_i;
  logic [NUM_CH-1:0]        ack_o;
  logic [LINE_W-1:0]        r_data_o;
  logic                     busy_o;
  modport master (output req_i, w_en_i, addr_i, w_data_i, input ack_o, r_data_o, busy_o);
  modport slave  (input req_i, w_en_i, addr_i, w_data_i, output ack_o, r_data_o, busy_o);
endinterface

// File: rtl/main_mem_mc_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, highest priority at i_ptr and wrapping upward
module rr_arbiter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx
);
  // walk from lowest to highest priority so the last hit is the winner
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % N]) begin
        o_gnt = N'(1) << ((int'(i_ptr) + k) % N);
        o_idx = W'((int'(i_ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/main_mem_mc.sv
// main_mem_mc: multi-channel line-granular main memory, round-robin arbitration, programmable latency.
// Optional per-channel read/write counters when MAIN_MEM_PERF_CNT_EN is defined.
module main_mem_mc
  import main_mem_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int LINE_W      = 128,
  parameter int DEPTH       = 4096,
  parameter int ADDR_W      = 32,
  parameter int MEM_LATENCY = 1,
  parameter     INIT_FILE   = ""
) (
  input  logic                 clk,
  input  logic                 rst_n,
  main_mem_mc_if.slave         bus,
  output logic [NUM_CH*32-1:0] rd_cnt_o,
  output logic [NUM_CH*32-1:0] wr_cnt_o
);
  localparam int OFF  = off_w(LINE_W);
  localparam int IDX_W = idx_w(DEPTH);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [LINE_W-1:0]    r_mem [DEPTH];
  main_mem_state_e      r_state, w_state_nx;
  logic [CH_W-1:0]      r_ch, r_ptr, w_gnt_idx;
  logic [NUM_CH-1:0]    w_gnt;
  logic                 r_wen, w_acc;
  logic [IDX_W-1:0]     r_idx;
  logic [LINE_W-1:0]    r_wdata, r_rdata;
  logic [LAT_CNT_W-1:0] r_cnt;

  rr_arbiter #(.N(NUM_CH), .W(CH_W)) u_arb (
    .i_req(bus.req_i),
    .i_ptr(r_ptr),
    .o_gnt(w_gnt),
    .o_idx(w_gnt_idx)
  );

  assign w_acc        = (r_state == WAIT) && (r_cnt == '0);
  assign bus.ack_o    = (r_state == RESP) ? (NUM_CH'(1) << r_ch) : '0;
  assign bus.busy_o   = (r_state != IDLE);
  assign bus.r_data_o = r_rdata;

  always_comb begin
    w_state_nx = r_state;
    w_state_nx = (r_state == IDLE) ? ((|bus.req_i) ? WAIT : IDLE) :
                 (r_state == WAIT) ? (w_acc ? RESP : WAIT) : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ch    <= '0;
      r_ptr   <= '0;
      r_wen   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == IDLE && |bus.req_i) begin
        r_ch    <= w_gnt_idx;
        r_wen   <= |(bus.w_en_i & w_gnt);
        r_idx   <= bus.addr_i[int'(w_gnt_idx)*ADDR_W + OFF +: IDX_W];
        r_wdata <= bus.w_data_i[int'(w_gnt_idx)*LINE_W +: LINE_W];
        r_cnt   <= LAT_CNT_W'(MEM_LATENCY - 1);
      end
      if (r_state == WAIT && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (w_acc && !r_wen) r_rdata <= r_mem[r_idx];
      if (r_state == RESP) r_ptr <= (int'(r_ch) == NUM_CH - 1) ? '0 : r_ch + 1'b1;
    end
  end

  // storage is not reset; a reset in WAIT forces IDLE so the pending write never lands
  always_ff @(posedge clk) begin
    if (w_acc && r_wen) r_mem[r_idx] <= r_wdata;
  end

`ifdef MAIN_MEM_PERF_CNT_EN
  logic [31:0] r_rd_cnt [NUM_CH];
  logic [31:0] r_wr_cnt [NUM_CH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_cnt <= '{default: '0};
      r_wr_cnt <= '{default: '0};
    end else if (r_state == RESP) begin
      if (r_wen && r_wr_cnt[r_ch] != '1) r_wr_cnt[r_ch] <= r_wr_cnt[r_ch] + 32'd1;
      if (!r_wen && r_rd_cnt[r_ch] != '1) r_rd_cnt[r_ch] <= r_rd_cnt[r_ch] + 32'd1;
    end
  end
  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    assign rd_cnt_o[g*32 +: 32] = r_rd_cnt[g];
    assign wr_cnt_o[g*32 +: 32] = r_wr_cnt[g];
  end
`else
  assign rd_cnt_o = '0;
  assign wr_cnt_o = '0;
`endif
endmodule

// File: tb/tb_main_mem_mc.sv
// tb_main_mem_mc: randomized checks of main_mem_mc against a line-array reference model.
// A second instance with MEM_LATENCY=4 covers the long-latency timing.
module tb_main_mem_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [63:0] rd_cnt, wr_cnt, rd_cnt4, wr_cnt4;
  int total = 0;
  int bad = 0;
  int mptr = 0;
  int rc [2];
  int wc [2];
  logic [127:0] last_rd = '0;
  logic [127:0] mdl [int];

  main_mem_mc_if #(.NUM_CH(2), .LINE_W(128), .ADDR_W(32)) b ();
  main_mem_mc_if #(.NUM_CH(2), .LINE_W(128), .ADDR_W(32)) b4 ();

  main_mem_mc dut (.clk(clk), .rst_n(rst_n), .bus(b), .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt));
  main_mem_mc #(.MEM_LATENCY(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4), .rd_cnt_o(rd_cnt4), .wr_cnt_o(wr_cnt4));

  always #5 clk = ~clk;

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 4) % 4096);
  endfunction

  function automatic logic [127:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    mptr = 0;
    last_rd = '0;
    rc = '{0, 0};
    wc = '{0, 0};
  endtask

  task automatic xfer(input int c, input bit we, input logic [31:0] a, input logic [127:0] d);
    int n;
    logic [127:0] exp;
    b.req_i[c] = 1'b1;
    b.w_en_i[c] = we;
    b.addr_i[c*32 +: 32] = a;
    b.w_data_i[c*128 +: 128] = d;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (b.ack_o == '0 && n < 40);
    total++;
    if (b.ack_o !== (2'b01 << c)) begin
      bad++;
      $display("FAIL xfer_ack ch=%0d got=%b want=%b", c, b.ack_o, 2'b01 << c);
    end
    total++;
    if (n != 2) begin
      bad++;
      $display("FAIL xfer_latency ch=%0d got=%0d want=2", c, n);
    end
    if (we) begin
      mdl[line_of(a)] = d;
      wc[c]++;
      exp = last_rd;
    end else begin
      exp = mdl[line_of(a)];
      last_rd = exp;
      rc[c]++;
    end
    mptr = (c + 1) % 2;
    total++;
    if (b.r_data_o !== exp) begin
      bad++;
      $display("FAIL xfer_rdata ch=%0d we=%0d got=%h want=%h", c, we, b.r_data_o, exp);
    end
    b.req_i[c] = 1'b0;
    @(negedge clk);
    total++;
    if (b.ack_o !== '0) begin
      bad++;
      $display("FAIL ack_one_cycle got=%b want=00", b.ack_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (b.ack_o !== '0 || b.busy_o !== 1'b0 || b.r_data_o !== '0) begin
      bad++;
      $display("FAIL reset_outputs ack=%b busy=%b rdata=%h want 0/0/0", b.ack_o, b.busy_o, b.r_data_o);
    end
    total++;
    if (rd_cnt !== '0 || wr_cnt !== '0) begin
      bad++;
      $display("FAIL reset_counters rd=%h wr=%h want 0", rd_cnt, wr_cnt);
    end
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_basic();
    xfer(0, 1'b1, 32'h40, {16{8'hA5}});
    xfer(0, 1'b0, 32'h40, '0);
    for (int i = 0; i < 8; i++) xfer(i % 2, 1'b1, 32'(i * 16), rnd_line());
    for (int i = 0; i < 6; i++) xfer($urandom_range(0, 1), 1'(i % 2), 32'($urandom_range(0, 7) * 16 + $urandom_range(0, 15)), rnd_line());
  endtask

  task automatic test_alias();
    logic [127:0] d;
    d = rnd_line();
    xfer(1, 1'b1, 32'h0001_0000, d);
    xfer(0, 1'b0, 32'h0000_0000, '0);
    xfer(1, 1'b0, 32'hFFFF_000C, '0);
  endtask

  task automatic test_back_to_back();
    bit p_we [2];
    logic [31:0] p_addr [2];
    logic [127:0] p_data [2], exp;
    int n, c;
    for (int k = 0; k < 2; k++) begin
      p_we[k] = 1'($urandom_range(0, 1));
      p_addr[k] = 32'($urandom_range(0, 7) * 16);
      p_data[k] = rnd_line();
      b.req_i[k] = 1'b1;
      b.w_en_i[k] = p_we[k];
      b.addr_i[k*32 +: 32] = p_addr[k];
      b.w_data_i[k*128 +: 128] = p_data[k];
    end
    for (int g = 0; g < 12; g++) begin
      n = 0;
      do begin
        @(posedge clk);
        n++;
        @(negedge clk);
      end while (b.ack_o == '0 && n < 40);
      c = b.ack_o[1] ? 1 : 0;
      total++;
      if (b.ack_o !== (2'b01 << mptr)) begin
        bad++;
        $display("FAIL rr_grant g=%0d got=%b want=%b", g, b.ack_o, 2'b01 << mptr);
      end
      total++;
      if (n != (g == 0 ? 2 : 3)) begin
        bad++;
        $display("FAIL rr_spacing g=%0d got=%0d want=%0d", g, n, g == 0 ? 2 : 3);
      end
      if (p_we[c]) begin
        mdl[line_of(p_addr[c])] = p_data[c];
        wc[c]++;
        exp = last_rd;
      end else begin
        exp = mdl[line_of(p_addr[c])];
        last_rd = exp;
        rc[c]++;
      end
      total++;
      if (b.r_data_o !== exp) begin
        bad++;
        $display("FAIL rr_rdata g=%0d ch=%0d got=%h want=%h", g, c, b.r_data_o, exp);
      end
      mptr = (c + 1) % 2;
      p_we[c] = 1'($urandom_range(0, 1));
      p_addr[c] = 32'($urandom_range(0, 7) * 16);
      p_data[c] = rnd_line();
      b.w_en_i[c] = p_we[c];
      b.addr_i[c*32 +: 32] = p_addr[c];
      b.w_data_i[c*128 +: 128] = p_data[c];
    end
    b.req_i = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency();
    int n, bc;
    logic [127:0] d;
    d = rnd_line();
    for (int k = 0; k < 2; k++) begin
      b4.req_i[0] = 1'b1;
      b4.w_en_i[0] = (k == 0);
      b4.addr_i[31:0] = 32'h30;
      b4.w_data_i[127:0] = d;
      n = 0;
      bc = 0;
      do begin
        @(posedge clk);
        n++;
        @(negedge clk);
        if (b4.busy_o) bc++;
      end while (b4.ack_o == '0 && n < 40);
      total++;
      if (n != 5 || b4.ack_o !== 2'b01) begin
        bad++;
        $display("FAIL lat4_ack k=%0d edges=%0d ack=%b want 5/01", k, n, b4.ack_o);
      end
      total++;
      if (bc != 5) begin
        bad++;
        $display("FAIL lat4_busy k=%0d got=%0d want=5", k, bc);
      end
      b4.req_i[0] = 1'b0;
      @(negedge clk);
    end
    total++;
    if (b4.r_data_o !== d) begin
      bad++;
      $display("FAIL lat4_rdata got=%h want=%h", b4.r_data_o, d);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] old;
    old = rnd_line();
    xfer(0, 1'b1, 32'h80, old);
    b.req_i[0] = 1'b1;
    b.w_en_i[0] = 1'b1;
    b.addr_i[31:0] = 32'h80;
    b.w_data_i[127:0] = ~old;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (b.busy_o !== 1'b1) begin
      bad++;
      $display("FAIL midrst_busy got=%b want=1", b.busy_o);
    end
    rst_n = 1'b0;
    b.req_i = '0;
    #1;
    total++;
    if (b.busy_o !== 1'b0 || b.ack_o !== '0) begin
      bad++;
      $display("FAIL midrst_abort busy=%b ack=%b want 0/00", b.busy_o, b.ack_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      total++;
      if (b.ack_o !== '0 || rd_cnt !== '0 || wr_cnt !== '0) begin
        bad++;
        $display("FAIL midrst_quiet ack=%b rd=%h wr=%h want 0", b.ack_o, rd_cnt, wr_cnt);
      end
    end
    xfer(1, 1'b0, 32'h80, '0);
  endtask

  task automatic test_perf();
    logic [31:0] er, ew;
    test_reset();
    xfer(1, 1'b1, 32'h100, rnd_line());
    xfer(1, 1'b0, 32'h100, '0);
    xfer(1, 1'b1, 32'h110, rnd_line());
    xfer(1, 1'b0, 32'h110, '0);
    xfer(1, 1'b0, 32'h100, '0);
    for (int k = 0; k < 2; k++) begin
`ifdef MAIN_MEM_PERF_CNT_EN
      er = 32'(rc[k]);
      ew = 32'(wc[k]);
`else
      er = '0;
      ew = '0;
`endif
      total++;
      if (rd_cnt[k*32 +: 32] !== er || wr_cnt[k*32 +: 32] !== ew) begin
        bad++;
        $display("FAIL perf_cnt ch=%0d rd=%0d wr=%0d want rd=%0d wr=%0d", k, rd_cnt[k*32 +: 32], wr_cnt[k*32 +: 32], er, ew);
      end
    end
  endtask

  initial begin
    b.req_i = '0;
    b.w_en_i = '0;
    b.addr_i = '0;
    b.w_data_i = '0;
    b4.req_i = '0;
    b4.w_en_i = '0;
    b4.addr_i = '0;
    b4.w_data_i = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_alias();
    test_back_to_back();
    test_latency();
    test_reset_mid();
    test_perf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
